// File: rtl/mini_pkg.sv
// Shared definitions for the MINI multi-precision arithmetic controller.
// Holds the FSM state encodings and the operation select codes.
package mini_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/Adder8bit.sv
// Combinational 8-bit adder with carry in/out, time-shared by adder_sequencer.
// Ports: A, B   - byte operands
//        CIN    - carry in
//        SUM    - byte sum
//        CARRY  - carry out of bit 7
module Adder8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    output logic [7:0] SUM,
    output logic       CARRY
);

    assign {CARRY, SUM} = {1'b0, A} + {1'b0, B} + {8'd0, CIN};

endmodule

// File: rtl/adder_sequencer.sv
// Multi-precision add/subtract controller. Processes NBYTES-wide operands one
// byte per clock (LSB first) through a single Adder8bit, chaining the carry
// through a register.
// Ports: CLK, RST (async, active-high)
//        START/READY handshake, OP (0 add, 1 subtract), A, B operands
//        DONE one-cycle pulse with RESULT, COUT (1 = no borrow on subtract), OVF
//
// state    | meaning
// ST_IDLE  | READY high, waiting for START
// ST_RUN   | one byte per cycle, idx selects the byte
// ST_FIN   | DONE pulse, outputs valid
module adder_sequencer
    import mini_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                OP,
    input  logic [8*NBYTES-1:0] A,
    input  logic [8*NBYTES-1:0] B,
    output logic                READY,
    output logic                DONE,
    output logic [8*NBYTES-1:0] RESULT,
    output logic                COUT,
    output logic                OVF
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    logic [1:0]      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [7:0]      add_a, add_b, add_sum;
    logic            add_carry;
    logic            a_msb, b_msb;

    // Byte offset is {idx, 3'b000}, i.e. idx*8, without any width extension.
    assign add_a = a_q[{idx_q, 3'b000} +: 8];
    assign add_b = b_q[{idx_q, 3'b000} +: 8];

    Adder8bit u_adder (
        .A     (add_a),
        .B     (add_b),
        .CIN   (carry_q),
        .SUM   (add_sum),
        .CARRY (add_carry)
    );

    // b_q already holds ~B for subtract, so the same-sign test covers both ops.
    assign a_msb = a_q[W-1];
    assign b_msb = b_q[W-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (idx_q == IDX_LAST) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        READY = (state_q == ST_IDLE);
        DONE  = (state_q == ST_FIN);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    a_d      = A;
                    b_d      = (OP == OP_SUB) ? ~B : B;
                    carry_d  = OP;
                    idx_d    = '0;
                    result_d = '0;
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 3'b000} +: 8] = add_sum;
                carry_d = add_carry;
                if (idx_q == IDX_LAST) begin
                    cout_d = add_carry;
                    ovf_d  = (a_msb == b_msb) && (add_sum[7] != a_msb);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign OVF    = ovf_q;

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Multi-precision add/subtract controller that time-shares one `Adder8bit` instance to add or subtract NBYTES-wide operands one byte per clock, least significant byte first, chaining the carry through a register. It sits between the MINI control logic and the 8-bit adder datapath. Operands are presented with a START/READY handshake, and the block returns a full-width RESULT, carry-out and signed overflow with a one-cycle DONE pulse.

## Interface
- NBYTES, 4, operand width in bytes; legal range 1..16
- CLK  in  1  system clock, rising-edge
- RST  in  1  reset; asynchronous, active-high
- START  in  1  request; sampled only while READY=1
- OP  in  1  0 = add (A+B), 1 = subtract (A−B)
- A  in  8*NBYTES  operand A; captured on accepted START
- B  in  8*NBYTES  operand B; captured on accepted START
- READY  out  1  high in IDLE only
- DONE  out  1  one-cycle pulse; RESULT, COUT and OVF are valid
- RESULT  out  8*NBYTES  sum or difference; held until next accepted START
- COUT  out  1  carry out of the top byte; for subtract, 1 = no borrow
- OVF  out  1  two's-complement overflow of the full-width operation

One clock (CLK). Reset RST is asynchronous and active-high.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE, with START=1 at an edge:
  - capture A into a_reg;
  - capture B into b_reg, inverted bitwise when OP=1;
  - carry_reg ← OP;
  - idx ← 0;
  - RESULT ← 0;
  - go to RUN.
- RUN, every edge:
  - adder inputs are A=a_reg byte idx, B=b_reg byte idx, CIN=carry_reg;
  - RESULT byte idx ← SUM;
  - carry_reg ← CARRY.
  - If idx = NBYTES−1: COUT ← CARRY; OVF ← (a_msb == b_msb) && (SUM[7] != a_msb), using the top byte's bit 7 of a_reg and of the already-inverted b_reg; go to FIN.
  - Otherwise idx ← idx+1.
- FIN: DONE=1 for exactly this cycle, then return to IDLE on the next edge.
- Arithmetic is modulo 2^(8*NBYTES). Subtract is A + ~B + 1.
- START outside IDLE is ignored, with no queuing.
- A, B and OP may change freely after acceptance; the captured copies are used.

## Timing
- Reset values: state=IDLE, READY=1, DONE=0, RESULT=0, COUT=0, OVF=0, idx=0, carry_reg=0.
- START accepted at edge k:
  - READY=0 from k;
  - RESULT byte i is written at edge k+1+i;
  - FIN is entered at edge k+NBYTES, so DONE=1 in cycle k+NBYTES to k+NBYTES+1;
  - READY=1 again after edge k+NBYTES+1.
- Latency is NBYTES+1 cycles from accepted START to DONE. Throughput is one operation per NBYTES+2 cycles.
- NBYTES=1: a single RUN cycle, then FIN.
- START held high continuously: a new operation is accepted on the first edge in IDLE after FIN.
- RST during RUN or FIN aborts immediately:
  - all outputs return to reset values;
  - DONE is not produced for the aborted operation;
  - the next START is accepted on the first edge after RST is released.
- The adder is combinational, so SUM and CARRY are used in the same cycle. There are no other combinational paths from inputs to outputs.

## Structure
- Shared package `mini_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2;
  - OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: one `Adder8bit` instance (A, B, CIN → SUM, CARRY). It is the only arithmetic in the block.
- idx width is clog2(NBYTES), with a minimum of 1. Byte select uses an indexed part-select on a_reg and b_reg.

## Test plan
- Byte carry: NBYTES=4, OP=0, A=0x000000FF, B=0x00000001. Required: DONE at cycle 5 after START; RESULT=0x00000100; COUT=0; OVF=0.
- Full wrap: A=0xFFFFFFFF, B=0x00000001, add. Required: RESULT=0x00000000; COUT=1; OVF=0.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, add. Required: RESULT=0x80000000; COUT=0; OVF=1.
- Subtract with borrow: A=5, B=10, OP=1. Required: RESULT=0xFFFFFFFB; COUT=0; OVF=0. Subtract without borrow: A=10, B=5. Required: RESULT=5; COUT=1.
- Busy ignore: during RUN, pulse START with A=1, B=1. Required: the first operation's result is unchanged; exactly one DONE; READY stays 0 until after FIN.
- Reset mid-op: assert RST while idx=2. Required: outputs immediately return to reset values (READY=1, RESULT=0); no DONE. A START after release completes normally with 104+10=114.
